fns_dec_pipe: RTL

- Parametrised, pipelined Fibonacci-numeral-system (FNS) decoder for the CAC local-AFNS datapath; successor to the fixed 8-bit-to-6-bit combinational decoders.
- Masks a CW-bit codeword with a per-bit enable, then sums the Fibonacci weights of the surviving 1-bits to recover DW-bit data.
- Fixed 2-cycle latency with valid/ready handshakes on both sides, plus synchronous flush and range-overflow flag.
- Weights are elaborated internally from CW; there are no FNS weight input ports.

---
 rtl/fns_pkg.sv | 33 +++
 rtl/fns_dec_pipe_if.sv | 26 ++
 rtl/fns_wsum.sv | 24 ++
 rtl/fns_dec_pipe.sv | 101 ++++++++++
 4 files changed

// File: rtl/fns_pkg.sv
// Fibonacci weight helpers for the FNS decoder: per-bit weight, total weight
// of a codeword, and the internal sum width derived from it.
package fns_pkg;

    function automatic int fib_w(input int i);
        int a;
        int b;
        int t;
        a = 1;
        b = 1;
        for (int k = 2; k <= i; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    function automatic int fib_sumw(input int cw);
        int s;
        s = 0;
        for (int k = 0; k < cw; k++) begin
            s = s + fib_w(k);
        end
        return s;
    endfunction

    // Width that holds the largest possible sum without truncation.
    function automatic int fns_sw(input int cw);
        return $clog2(fib_sumw(cw) + 1);
    endfunction

endpackage

// File: rtl/fns_dec_pipe_if.sv
// Codeword-in / decoded-word-out handshake bundle for fns_dec_pipe.
// The slave side is the decoder; the master side is whoever feeds and drains it.
interface fns_dec_pipe_if #(
    parameter int CW = 8,
    parameter int DW = 6
);
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] codein;
    logic [CW-1:0] en_flag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] dataout;
    logic          err_ovf;

    modport master (
        output flush, in_valid, codein, en_flag, out_ready,
        input  in_ready, out_valid, dataout, err_ovf
    );

    modport slave (
        input  flush, in_valid, codein, en_flag, out_ready,
        output in_ready, out_valid, dataout, err_ovf
    );
endinterface

// File: rtl/fns_wsum.sv
// Combinational masked Fibonacci-weighted sum over codeword bits [HI:LO].
// No state; result is valid in the same cycle as the mask.
module fns_wsum
    import fns_pkg::*;
#(
    parameter int CW = 8,
    parameter int LO = 0,
    parameter int HI = 3,
    parameter int SW = 6
) (
    input  logic [CW-1:0] m,
    output logic [SW-1:0] sum
);

    always_comb begin
        sum = '0;
        for (int i = LO; i <= HI; i++) begin
            if (m[i]) begin
                sum = sum + SW'(fib_w(i));
            end
        end
    end

endmodule

// File: rtl/fns_dec_pipe.sv
// Two-stage FNS decoder: stage 1 holds two partial weight sums, stage 2 the final value and overflow flag.
// Latency 2 cycles, 1 word/cycle; out_ready low stalls stage 2, then stage 1, then drops in_ready.
module fns_dec_pipe
    import fns_pkg::*;
#(
    parameter int CW    = 8,
    parameter int DW    = 6,
    parameter int SPLIT = CW / 2
) (
    input  logic          clk,
    input  logic          rst,
    fns_dec_pipe_if.slave bus
);

    localparam int SW = fns_sw(CW);
    // One spare bit over the wider of SW/DW keeps the overflow compare lossless.
    localparam int MW = ((SW > DW) ? SW : DW) + 1;

    logic [CW-1:0] m;
    logic [SW-1:0] suma, sumb;

    logic          s1_valid_q, s1_valid_d;
    logic [SW-1:0] s1_suma_q, s1_suma_d;
    logic [SW-1:0] s1_sumb_q, s1_sumb_d;
    logic          s2_valid_q, s2_valid_d;
    logic [DW-1:0] s2_dat_q, s2_dat_d;
    logic          s2_ovf_q, s2_ovf_d;

    logic          s2_load;
    logic          accept;
    logic [MW-1:0] sum_ext;

    assign m = bus.codein & bus.en_flag;

    fns_wsum #(.CW(CW), .LO(0), .HI(SPLIT - 1), .SW(SW)) u_wsum_a (
        .m   (m),
        .sum (suma)
    );

    fns_wsum #(.CW(CW), .LO(SPLIT), .HI(CW - 1), .SW(SW)) u_wsum_b (
        .m   (m),
        .sum (sumb)
    );

    assign s2_load     = !s2_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid_q || s2_load;
    assign accept      = bus.in_valid && bus.in_ready;
    assign sum_ext     = MW'(s1_suma_q) + MW'(s1_sumb_q);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_suma_d  = s1_suma_q;
        s1_sumb_d  = s1_sumb_q;
        s2_valid_d = s2_valid_q;
        s2_dat_d   = s2_dat_q;
        s2_ovf_d   = s2_ovf_q;

        if (bus.flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    s2_dat_d = sum_ext[DW-1:0];
                    s2_ovf_d = sum_ext > {{(MW - DW){1'b0}}, {DW{1'b1}}};
                end
                s1_valid_d = 1'b0;
            end
            if (accept) begin
                s1_valid_d = 1'b1;
                s1_suma_d  = suma;
                s1_sumb_d  = sumb;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_suma_q  <= '0;
            s1_sumb_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_dat_q   <= '0;
            s2_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_suma_q  <= s1_suma_d;
            s1_sumb_q  <= s1_sumb_d;
            s2_valid_q <= s2_valid_d;
            s2_dat_q   <= s2_dat_d;
            s2_ovf_q   <= s2_ovf_d;
        end
    end

    // Stale stage-2 data after a flush must never leak onto the outputs.
    assign bus.out_valid = s2_valid_q;
    assign bus.dataout   = s2_valid_q ? s2_dat_q : '0;
    assign bus.err_ovf   = s2_valid_q && s2_ovf_q;

endmodule
